if_fetch_unit: RTL and testbench



---
 rtl/if_fetch_unit.sv | 135 +++++++++++++
 tb/tb_if_fetch_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: holds the PC, fetches one word per request/valid
// handshake and computes the next PC from the controller's NPCOp at commit.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rstn,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_valid,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      instr,
    output logic             instr_valid,
    output logic [5:0]       Op,
    output logic [5:0]       Funct,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    input  logic             commit,
    input  logic [1:0]       NPCOp,
    input  logic [31:0]      rs_data,
    output logic             fetch_err,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_e;

    localparam logic [1:0] NPC_PLUS4  = 2'b00;
    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JUMP   = 2'b10;
    localparam logic [1:0] NPC_JUMPR  = 2'b11;

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      pc4_q, pc4_d;
    logic [31:0]      instr_q, instr_d;
    logic             ivalid_q, ivalid_d;
    logic             req_q, req_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] ret_q, ret_d;

    logic [31:0] npc;
    logic [31:0] br_off;
    logic        misalign;

    assign br_off   = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    assign misalign = (NPCOp == NPC_JUMPR) && (rs_data[1:0] != 2'b00);

    // pc_plus4 is kept registered, so it doubles as the sequential successor
    always_comb begin
        npc = pc4_q;
        unique case (NPCOp)
            NPC_PLUS4:  npc = pc4_q;
            NPC_BRANCH: npc = pc4_q + br_off;
            NPC_JUMP:   npc = {pc4_q[31:28], instr_q[25:0], 2'b00};
            NPC_JUMPR:  npc = {rs_data[31:2], 2'b00};
            default:    npc = pc4_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        pc4_d    = pc4_q;
        instr_d  = instr_q;
        ivalid_d = ivalid_q;
        req_d    = req_q;
        err_d    = err_q;
        ret_d    = ret_q;
        unique case (state_q)
            FETCH: begin
                req_d = 1'b1;
                // a response only counts against a request already on the bus
                if (req_q && imem_valid) begin
                    instr_d  = imem_rdata;
                    ivalid_d = 1'b1;
                    req_d    = 1'b0;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                req_d = 1'b0;
                if (commit) begin
                    pc_d     = npc;
                    pc4_d    = npc + 32'd4;
                    ivalid_d = 1'b0;
                    ret_d    = ret_q + CNT_W'(1);
                    req_d    = 1'b1;
                    state_d  = FETCH;
                    if (misalign) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            pc4_q    <= RESET_PC + 32'd4;
            instr_q  <= 32'd0;
            ivalid_q <= 1'b0;
            req_q    <= 1'b0;
            err_q    <= 1'b0;
            ret_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pc4_q    <= pc4_d;
            instr_q  <= instr_d;
            ivalid_q <= ivalid_d;
            req_q    <= req_d;
            err_q    <= err_d;
            ret_q    <= ret_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = ivalid_q;
    assign Op          = instr_q[31:26];
    assign Funct       = instr_q[5:0];
    assign pc          = pc_q;
    assign pc_plus4    = pc4_q;
    assign fetch_err   = err_q;
    assign retired     = ret_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed table, reset corner cases and random
// traffic against a next-PC reference model with a variable-latency memory.
module tb_if_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [5:0]  Op;
    logic [5:0]  Funct;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        commit = 1'b0;
    logic [1:0]  NPCOp = 2'b00;
    logic [31:0] rs_data = 32'd0;
    logic        fetch_err;
    logic [31:0] retired;

    if_fetch_unit #(.RESET_PC(RST_PC), .CNT_W(32)) dut (
        .clk(clk), .rstn(rstn),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid),
        .Op(Op), .Funct(Funct),
        .pc(pc), .pc_plus4(pc_plus4),
        .commit(commit), .NPCOp(NPCOp), .rs_data(rs_data),
        .fetch_err(fetch_err), .retired(retired)
    );

    always #5 clk = ~clk;

    // memory: answers after lat_v wait cycles, drops state on reset
    int          lat_v = 0;
    int          wcnt;
    logic        stale = 1'b0;
    logic [31:0] mem_word = 32'd0;

    assign imem_valid = (imem_req && (wcnt == lat_v)) || stale;
    assign imem_rdata = mem_word;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) wcnt <= 0;
        else if (imem_req && !imem_valid) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [31:0] m_pc  = RST_PC;
    logic [31:0] m_ret = 0;
    logic        m_err = 1'b0;
    logic [31:0] m_w   = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = RST_PC;
        m_ret = 0;
        m_err = 1'b0;
        m_w = 0;
    endtask

    task automatic model_commit(input logic [1:0] op, input logic [31:0] rs);
        logic [31:0] p4;
        int off;
        p4 = m_pc + 32'd4;
        off = int'($signed(m_w[15:0]));
        case (op)
            2'd0: m_pc = p4;
            2'd1: m_pc = p4 + 32'(off * 4);
            2'd2: m_pc = (p4 & 32'hF000_0000) | ((m_w & 32'h03FF_FFFF) * 4);
            default: begin
                m_pc = rs - (rs % 4);
                if (rs % 4 != 0) m_err = 1'b1;
            end
        endcase
        m_ret = m_ret + 1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_req"}, {31'd0, imem_req}, 0);
        chk({tag, "_addr"}, imem_addr, RST_PC);
        chk({tag, "_pc"}, pc, RST_PC);
        chk({tag, "_pc4"}, pc_plus4, RST_PC + 4);
        chk({tag, "_instr"}, instr, 0);
        chk({tag, "_ivalid"}, {31'd0, instr_valid}, 0);
        chk({tag, "_op"}, {26'd0, Op}, 0);
        chk({tag, "_funct"}, {26'd0, Funct}, 0);
        chk({tag, "_err"}, {31'd0, fetch_err}, 0);
        chk({tag, "_retired"}, retired, 0);
    endtask

    // called at a negedge in FETCH; returns at a negedge in HOLD
    task automatic fetch(input logic [31:0] w, input int l, input bit stray);
        int n;
        bit got;
        mem_word = w;
        lat_v = l;
        n = 0;
        got = 0;
        for (int c = 0; c < 40; c++) begin
            if (instr_valid) begin
                got = 1;
                break;
            end
            chk("fetch_req", {31'd0, imem_req}, 1);
            chk("fetch_addr", imem_addr, m_pc);
            n++;
            if (stray) commit = 1'b1;
            @(posedge clk);
            #1 commit = 1'b0;
            @(negedge clk);
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL fetch_timeout got no instr_valid want instr_valid");
            return;
        end
        m_w = w;
        chk("fetch_cycles", n, l + 1);
        chk("instr", instr, w);
        chk("op", {26'd0, Op}, {26'd0, w[31:26]});
        chk("funct", {26'd0, Funct}, {26'd0, w[5:0]});
        chk("retired_hold", retired, m_ret);
        chk("pc_hold", pc, m_pc);
    endtask

    // called at a negedge in HOLD; returns at a negedge in FETCH
    task automatic commit_op(input logic [1:0] op, input logic [31:0] rs);
        NPCOp = op;
        rs_data = rs;
        commit = 1'b1;
        @(posedge clk);
        #1 commit = 1'b0;
        model_commit(op, rs);
        @(negedge clk);
        chk("npc", pc, m_pc);
        chk("npc_plus4", pc_plus4, m_pc + 4);
        chk("retired", retired, m_ret);
        chk("fetch_err", {31'd0, fetch_err}, {31'd0, m_err});
        chk("ivalid_clr", {31'd0, instr_valid}, 0);
    endtask

    typedef struct {
        logic [31:0] w;
        logic [1:0]  op;
        logic [31:0] rs;
        int          lat;
        bit          stray;
        logic [31:0] exp_pc;
        bit          exp_err;
    } vec_t;

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{32'h2008_0005, 2'd0, 32'h0,         0, 0, 32'h0000_3004, 0};
        tbl[1]  = '{32'h0000_0020, 2'd0, 32'h0,         3, 1, 32'h0000_3008, 0};
        tbl[2]  = '{32'h0800_0C10, 2'd2, 32'h0,         0, 0, 32'h0000_3040, 0};
        tbl[3]  = '{32'h03E0_0008, 2'd3, 32'h0000_3010, 0, 0, 32'h0000_3010, 0};
        tbl[4]  = '{32'h1000_FFFC, 2'd1, 32'h0,         0, 0, 32'h0000_3004, 0};
        tbl[5]  = '{32'h03E0_0008, 2'd3, 32'h0000_3010, 1, 0, 32'h0000_3010, 0};
        tbl[6]  = '{32'h1000_0003, 2'd1, 32'h0,         2, 1, 32'h0000_3020, 0};
        tbl[7]  = '{32'h03E0_0008, 2'd3, 32'h0000_3101, 0, 0, 32'h0000_3100, 1};
        tbl[8]  = '{32'h2008_0005, 2'd0, 32'h0,         0, 0, 32'h0000_3104, 1};
        tbl[9]  = '{32'h03E0_0008, 2'd3, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 1};
        tbl[10] = '{32'h2008_0005, 2'd0, 32'h0,         0, 0, 32'h0000_0000, 1};

        repeat (2) @(negedge clk);
        check_reset_vals("por");
        rstn = 1'b1;
        @(negedge clk);
        chk("cyc1_req", {31'd0, imem_req}, 1);
        chk("cyc1_addr", imem_addr, RST_PC);

        for (int i = 0; i < 11; i++) begin
            fetch(tbl[i].w, tbl[i].lat, tbl[i].stray);
            commit_op(tbl[i].op, tbl[i].rs);
            chk($sformatf("tbl%0d_pc", i), pc, tbl[i].exp_pc);
            chk($sformatf("tbl%0d_err", i), {31'd0, fetch_err},
                {31'd0, tbl[i].exp_err});
        end
        chk("wrap_pc4", pc_plus4, 32'h0000_0004);

        // asynchronous reset while fetching
        lat_v = 3;
        @(posedge clk);
        #2 rstn = 1'b0;
        #1 check_reset_vals("rst_fetch");
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
        @(negedge clk);
        fetch(32'h2008_0005, 3, 0);

        // asynchronous reset while holding an instruction
        @(posedge clk);
        #2 rstn = 1'b0;
        #1 check_reset_vals("rst_hold");
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
        @(negedge clk);
        fetch(32'h1234_5678, 0, 0);

        // stale response during HOLD must not disturb the latched word
        mem_word = 32'hDEAD_BEEF;
        stale = 1'b1;
        repeat (3) @(negedge clk);
        chk("stale_instr", instr, 32'h1234_5678);
        chk("stale_ivalid", {31'd0, instr_valid}, 1);
        chk("stale_pc", pc, RST_PC);
        stale = 1'b0;
        commit_op(2'd0, 32'd0);

        for (int k = 0; k < 40; k++) begin
            logic [31:0] w;
            logic [31:0] rs;
            logic [1:0]  op;
            w = $urandom;
            rs = $urandom;
            op = 2'($urandom_range(0, 3));
            fetch(w, $urandom_range(0, 3), bit'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                chk("hold_ivalid", {31'd0, instr_valid}, 1);
                chk("hold_req", {31'd0, imem_req}, 0);
            end
            commit_op(op, rs);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
